inta_sequencer: RTL

INTA_SEQUENCER -- requirements
Module: inta_sequencer

---
 rtl/inta_sequencer.sv | 109 ++++++++++
 1 files changed

// File: rtl/inta_sequencer.sv
// 8-input fixed-priority interrupt acknowledge sequencer: two-pulse INTA vector cycle with in-service tracking.
// Optional build macro AEOI_EN: the rising edge of inta_n that ends the vector pulse also clears ISR[idx].
module inta_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] IRR_Output,
    input  logic [7:0] IMR,
    input  logic [4:0] vector_base,
    input  logic       inta_n,
    input  logic       eoi,
    output logic       int_out,
    output logic [7:0] clear_IRR,
    output logic       freeze,
    output logic [7:0] ISR,
    output logic [7:0] data_out,
    output logic       data_oe
);

    typedef enum logic [2:0] {IDLE, PEND, ACK1, WAIT2, ACK2} state_e;

    state_e     state_q, state_d;
    logic       inta_q;
    logic [7:0] isr_q, isr_d;
    logic [7:0] clear_q, clear_d;
    logic [2:0] idx_q, idx_d;
    logic       spurious_q, spurious_d;

    logic [7:0] req, elig, grant, isr_lsb, set_vec, eoi_clr, aeoi_clr;
    logic [2:0] pick_idx;
    logic       inta_fall, inta_rise;

    assign req       = IRR_Output & ~IMR;
    // Isolate the highest-priority in-service bit; only strictly lower indices may interrupt it.
    assign isr_lsb   = isr_q & (~isr_q + 8'd1);
    assign elig      = req & ((isr_q == 8'h00) ? 8'hFF : (isr_lsb - 8'd1));
    assign grant     = elig & (~elig + 8'd1);
    assign inta_fall = inta_q & ~inta_n;
    assign inta_rise = ~inta_q & inta_n;
    assign eoi_clr   = eoi ? isr_lsb : 8'h00;

    always_comb begin
        pick_idx = 3'd7;
        for (int i = 7; i >= 0; i--) begin
            if (elig[i]) pick_idx = 3'(i);
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        idx_d      = idx_q;
        spurious_d = spurious_q;
        clear_d    = 8'h00;
        set_vec    = 8'h00;
        aeoi_clr   = 8'h00;
        case (state_q)
            IDLE:  if (|elig) state_d = PEND;
            PEND: begin
                if (inta_fall) begin
                    state_d    = ACK1;
                    idx_d      = pick_idx;
                    spurious_d = ~|elig;
                    set_vec    = grant;
                    clear_d    = grant;
                end
            end
            ACK1:  if (inta_rise) state_d = WAIT2;
            WAIT2: if (inta_fall) state_d = ACK2;
            ACK2: begin
                if (inta_rise) begin
                    state_d = IDLE;
`ifdef AEOI_EN
                    if (!spurious_q) aeoi_clr = 8'h01 << idx_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        // Set after clear so a same-cycle set of the eoi target bit wins.
        isr_d = (isr_q & ~eoi_clr & ~aeoi_clr) | set_vec;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            inta_q     <= 1'b1;
            isr_q      <= 8'h00;
            clear_q    <= 8'h00;
            idx_q      <= 3'd0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inta_q     <= inta_n;
            isr_q      <= isr_d;
            clear_q    <= clear_d;
            idx_q      <= idx_d;
            spurious_q <= spurious_d;
        end
    end

    assign int_out   = (state_q == PEND);
    assign freeze    = (state_q == ACK1) || (state_q == WAIT2) || ((state_q == ACK2) && !inta_rise);
    assign data_oe   = (state_q == ACK2) && !inta_n;
    assign data_out  = data_oe ? {vector_base, idx_q} : 8'h00;
    assign clear_IRR = clear_q;
    assign ISR       = isr_q;

endmodule
